// File: rtl/knight_pkg.sv
// Shared constants and types for the Knight motor drive path.
package knight_pkg;

    localparam int unsigned PWM_BITS   = 11;
    localparam int unsigned PWM_PERIOD = 2048;
    localparam logic [PWM_BITS-1:0] DUTY_MID = 11'h400;

    typedef logic signed [PWM_BITS-1:0] spd_t;

    // Offset-binary mapping: -1024 -> 0, 0 -> 1024, +1023 -> 2047.
    function automatic logic [PWM_BITS-1:0] spd2duty(input spd_t spd);
        return PWM_BITS'(spd) ^ DUTY_MID;
    endfunction

endpackage

// File: rtl/mtr_drv_pwm11.sv
// One complementary PWM pair with a double-buffered duty and symmetric dead-time.
module pwm11
    import knight_pkg::*;
#(
    parameter int unsigned DEADTIME = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [PWM_BITS-1:0] cnt,
    output logic                PWM1,
    output logic                PWM2
);

    localparam int unsigned CMP_BITS = PWM_BITS + 1;

    logic [PWM_BITS-1:0] duty_buf_q, duty_buf_d;
    logic                pwm1_q, pwm1_d;
    logic                pwm2_q, pwm2_d;
    logic                lead_ok;

    // With no dead-time the leading guard is always satisfied.
    generate
        if (DEADTIME == 0) begin : g_no_dt
            assign lead_ok = 1'b1;
        end else begin : g_dt
            assign lead_ok = (cnt >= PWM_BITS'(DEADTIME));
        end
    endgenerate

    // 12-bit trailing compare keeps duty + DEADTIME from wrapping past the period.
    always_comb begin
        duty_buf_d = duty_buf_q;
        if (cnt == {PWM_BITS{1'b1}}) begin
            duty_buf_d = duty;
        end
        pwm1_d = lead_ok && (cnt < duty_buf_q);
        pwm2_d = ({1'b0, cnt} >= ({1'b0, duty_buf_q} + CMP_BITS'(DEADTIME)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_buf_q <= DUTY_MID;
            pwm1_q     <= 1'b0;
            pwm2_q     <= 1'b0;
        end else begin
            duty_buf_q <= duty_buf_d;
            pwm1_q     <= pwm1_d;
            pwm2_q     <= pwm2_d;
        end
    end

    assign PWM1 = pwm1_q;
    assign PWM2 = pwm2_q;

endmodule

// File: rtl/mtr_drv.sv
// Motor drive stage: shared period counter feeding left/right complementary PWM pairs.
module mtr_drv
    import knight_pkg::*;
#(
    parameter int unsigned DEADTIME = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] lft_spd,
    input  logic [PWM_BITS-1:0] rght_spd,
    output logic                lftPWM1,
    output logic                lftPWM2,
    output logic                rghtPWM1,
    output logic                rghtPWM2,
    output logic                prd_strt
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'(PWM_PERIOD - 1);

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                prd_strt_q, prd_strt_d;
    logic [PWM_BITS-1:0] lft_duty_c, rght_duty_c;

    always_comb begin
        cnt_d      = (cnt_q == CNT_MAX) ? '0 : cnt_q + PWM_BITS'(1);
        prd_strt_d = (cnt_q == '0);
        lft_duty_c  = spd2duty(spd_t'(lft_spd));
        rght_duty_c = spd2duty(spd_t'(rght_spd));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            prd_strt_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            prd_strt_q <= prd_strt_d;
        end
    end

    assign prd_strt = prd_strt_q;

    pwm11 #(.DEADTIME(DEADTIME)) u_lft (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (lft_duty_c),
        .cnt   (cnt_q),
        .PWM1  (lftPWM1),
        .PWM2  (lftPWM2)
    );

    pwm11 #(.DEADTIME(DEADTIME)) u_rght (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (rght_duty_c),
        .cnt   (cnt_q),
        .PWM1  (rghtPWM1),
        .PWM2  (rghtPWM2)
    );

endmodule

// File: tb/tb_mtr_drv.sv
// Self-checking bench for mtr_drv: per-period high-time counts against hand-computed values.
module tb_mtr_drv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] lft_spd = 11'd0;
    logic [10:0] rght_spd = 11'd0;
    logic        lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt;
    logic        l0_p1, l0_p2, r0_p1, r0_p2, ps0;

    always #10 clk = ~clk;

    mtr_drv #(.DEADTIME(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .lftPWM1  (lftPWM1),
        .lftPWM2  (lftPWM2),
        .rghtPWM1 (rghtPWM1),
        .rghtPWM2 (rghtPWM2),
        .prd_strt (prd_strt)
    );

    // Zero dead-time instance: its pair must be exact complements.
    mtr_drv #(.DEADTIME(0)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .lftPWM1  (l0_p1),
        .lftPWM2  (l0_p2),
        .rghtPWM1 (r0_p1),
        .rghtPWM2 (r0_p2),
        .prd_strt (ps0)
    );

    int errs = 0;
    int checks = 0;
    int m_l1, m_l2, m_r1, m_r2, m_wait, m_ovl, m_xps, m_cmp;

    typedef struct {
        int ls;
        int rs;
        int l1;
        int l2;
        int r1;
        int r2;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_hi1(input int spd);
        int d;
        d = spd + 1024 - 8;
        return (d > 0) ? d : 0;
    endfunction

    function automatic int exp_hi2(input int spd);
        int d;
        d = 2048 - (spd + 1024) - 8;
        return (d > 0) ? d : 0;
    endfunction

    // Find the next period start (bounded), then count one 2048-sample period.
    task automatic measure(input int step_idx, input int sl, input int sr);
        m_wait = 0;
        do begin
            @(negedge clk);
            m_wait++;
        end while (!prd_strt && m_wait < 5000);
        chk("period_start_seen", int'(prd_strt), 1);
        m_l1 = 0; m_l2 = 0; m_r1 = 0; m_r2 = 0;
        m_ovl = 0; m_xps = 0; m_cmp = 0;
        for (int i = 0; i < 2048; i++) begin
            if (i > 0) @(negedge clk);
            m_l1 += int'(lftPWM1);
            m_l2 += int'(lftPWM2);
            m_r1 += int'(rghtPWM1);
            m_r2 += int'(rghtPWM2);
            if ((lftPWM1 && lftPWM2) || (rghtPWM1 && rghtPWM2)) m_ovl++;
            if (i > 0 && prd_strt) m_xps++;
            if ((l0_p1 == l0_p2) || (r0_p1 == r0_p2)) m_cmp++;
            if (i == step_idx) begin
                lft_spd  = 11'(sl);
                rght_spd = 11'(sr);
            end
        end
    endtask

    task automatic chk_counts(input string tag, input int l1, input int l2,
                              input int r1, input int r2);
        chk({tag, "_lftPWM1"}, m_l1, l1);
        chk({tag, "_lftPWM2"}, m_l2, l2);
        chk({tag, "_rghtPWM1"}, m_r1, r1);
        chk({tag, "_rghtPWM2"}, m_r2, r2);
        chk({tag, "_overlap"}, m_ovl, 0);
        chk({tag, "_extra_prd_strt"}, m_xps, 0);
        chk({tag, "_dt0_complement"}, m_cmp, 0);
    endtask

    task automatic chk_all_low(input string tag);
        chk({tag, "_lftPWM1"}, int'(lftPWM1), 0);
        chk({tag, "_lftPWM2"}, int'(lftPWM2), 0);
        chk({tag, "_rghtPWM1"}, int'(rghtPWM1), 0);
        chk({tag, "_rghtPWM2"}, int'(rghtPWM2), 0);
        chk({tag, "_prd_strt"}, int'(prd_strt), 0);
    endtask

    initial begin
        int pls, prs, nls, nrs;

        vecs[0] = '{ls:     0, rs:     0, l1: 1016, l2: 1016, r1: 1016, r2: 1016};
        vecs[1] = '{ls:     0, rs:  1023, l1: 1016, l2: 1016, r1: 2039, r2:    0};
        vecs[2] = '{ls:     0, rs: -1024, l1: 1016, l2: 1016, r1:    0, r2: 2040};
        vecs[3] = '{ls:   512, rs:  -512, l1: 1528, l2:  504, r1:  504, r2: 1528};
        vecs[4] = '{ls:    -1, rs:     1, l1: 1015, l2: 1017, r1: 1017, r2: 1015};
        vecs[5] = '{ls:  1016, rs: -1016, l1: 2032, l2:    0, r1:    0, r2: 2032};
        vecs[6] = '{ls:  1017, rs: -1017, l1: 2033, l2:    0, r1:    0, r2: 2033};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_low("reset");
        rst_n = 1'b1;

        // Steady-state table: first period may still hold the old duty.
        foreach (vecs[k]) begin
            lft_spd  = 11'(vecs[k].ls);
            rght_spd = 11'(vecs[k].rs);
            measure(-1, 0, 0);
            measure(-1, 0, 0);
            chk_counts($sformatf("vec%0d", k), vecs[k].l1, vecs[k].l2, vecs[k].r1, vecs[k].r2);
        end

        // Mid-period step only takes effect at the next period.
        lft_spd  = 11'd0;
        rght_spd = 11'd0;
        measure(-1, 0, 0);
        measure(1000, 512, 0);
        chk_counts("step_cur", 1016, 1016, 1016, 1016);
        measure(-1, 0, 0);
        chk_counts("step_next", 1528, 504, 1016, 1016);

        // Random speeds, each changed mid-period and checked one period later.
        pls = 0;
        prs = 0;
        for (int p = 0; p < 11; p++) begin
            nls = int'($urandom_range(0, 2000)) - 1000;
            nrs = int'($urandom_range(0, 2000)) - 1000;
            measure(1000, nls, nrs);
            if (p > 0) begin
                chk($sformatf("rnd%0d_lft_diff", p), m_l1 - m_l2, 2 * pls);
                chk($sformatf("rnd%0d_rght_diff", p), m_r1 - m_r2, 2 * prs);
                chk($sformatf("rnd%0d_lftPWM1", p), m_l1, exp_hi1(pls));
                chk($sformatf("rnd%0d_rghtPWM2", p), m_r2, exp_hi2(prs));
                chk($sformatf("rnd%0d_overlap", p), m_ovl, 0);
            end
            pls = nls;
            prs = nrs;
        end

        // Reset at cnt=700 restores duty 1024 for the following period.
        lft_spd  = 11'(300);
        rght_spd = 11'(-300);
        measure(-1, 0, 0);
        measure(-1, 0, 0);
        chk_counts("pre_rst", 1316, 716, 716, 1316);
        m_wait = 0;
        do begin
            @(negedge clk);
            m_wait++;
        end while (!prd_strt && m_wait < 5000);
        chk("rst_sync_seen", int'(prd_strt), 1);
        repeat (700) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_low("mid_rst");
        rst_n = 1'b1;
        measure(-1, 0, 0);
        chk("post_rst_prd_strt_delay", m_wait, 1);
        chk_counts("post_rst", 1016, 1016, 1016, 1016);
        measure(-1, 0, 0);
        chk_counts("post_rst_next", 1316, 716, 716, 1316);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
